// File: rtl/led_pulse_scheduler_if.sv
// Bundle between the event logic, the scheduler and the LED pulse generator.
// The slave modport is the scheduler's view; the master modport is the
// view of whoever drives requests and consumes the trigger.
interface led_pulse_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*32-1:0] pulse_len;
    logic                  enable;
    logic                  trigger;
    logic [31:0]           pulse_cycles;
    logic [2:0]            owner;
    logic                  busy;
    logic [NUM_REQ-1:0]    pending;
    logic [15:0]           drop_count;

    modport master (
        output req, pulse_len, enable,
        input  trigger, pulse_cycles, owner, busy, pending, drop_count
    );

    modport slave (
        input  req, pulse_len, enable,
        output trigger, pulse_cycles, owner, busy, pending, drop_count
    );
endinterface

// File: rtl/led_pulse_scheduler.sv
// Round-robin scheduler sharing one LED pulse generator between NUM_REQ
// event sources. Requests are latched, granted one at a time, and every
// pulse is followed by a dark gap so consecutive flashes stay distinct.
module led_pulse_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int CLOCK_HZ   = 25_000_000,
    parameter int GAP_CYCLES = CLOCK_HZ / 10
) (
    input  logic                   clk,
    input  logic                   rst,
    led_pulse_scheduler_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         owner_q, owner_d;
    logic [31:0]        pulse_cycles_q, pulse_cycles_d;
    logic               trigger_q, trigger_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [15:0]        drop_q, drop_d;

    logic               found;
    logic [2:0]         winner;
    logic [NUM_REQ-1:0] clear_mask;
    logic [NUM_REQ-1:0] drop_mask;
    logic [3:0]         drop_cnt;
    logic [31:0]        grant_len;

    // Saturating add so the lost-request counter sticks at 0xFFFF.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {13'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // A zero-length request still produces a visible one-cycle pulse.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

    // Round-robin search: first pending bit after the last winner, wrapping.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = ptr_q;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && pending_q[idx[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    assign grant_len = clamp_len(bus.pulse_len[int'(winner)*32 +: 32]);

    // Next-state logic: grant from IDLE, count down PULSE and GAP, latch requests.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        pulse_cycles_d = pulse_cycles_q;
        trigger_d      = 1'b0;
        clear_mask     = '0;

        case (state_q)
            IDLE: begin
                if (bus.enable && found) begin
                    trigger_d      = 1'b1;
                    pulse_cycles_d = grant_len;
                    owner_d        = winner;
                    ptr_d          = winner;
                    clear_mask     = NUM_REQ'(1) << winner;
                    timer_d        = grant_len;
                    state_d        = PULSE;
                end
            end
            PULSE: begin
                if (timer_q == 32'd1) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        timer_d = 32'd0;
                    end else begin
                        state_d = GAP;
                        timer_d = 32'(GAP_CYCLES);
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            GAP: begin
                if (timer_q == 32'd1) begin
                    state_d = IDLE;
                    timer_d = 32'd0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 32'd0;
            end
        endcase

        // A request arriving while its bit is being granted is a fresh request,
        // not a coalesced one.
        drop_mask = bus.req & pending_q & ~clear_mask;
        pending_d = (pending_q & ~clear_mask) | bus.req;
        drop_cnt  = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drop_cnt = drop_cnt + 4'(drop_mask[i]);
        end
        drop_d = sat_add16(drop_q, drop_cnt);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            timer_q        <= 32'd0;
            ptr_q          <= 3'(NUM_REQ - 1);
            owner_q        <= 3'd0;
            pulse_cycles_q <= 32'd0;
            trigger_q      <= 1'b0;
            pending_q      <= '0;
            drop_q         <= 16'd0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            pulse_cycles_q <= pulse_cycles_d;
            trigger_q      <= trigger_d;
            pending_q      <= pending_d;
            drop_q         <= drop_d;
        end
    end

    assign bus.trigger      = trigger_q;
    assign bus.pulse_cycles = pulse_cycles_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.pending      = pending_q;
    assign bus.drop_count   = drop_q;
endmodule

// File: tb/tb_led_pulse_scheduler.sv
// Directed bench for led_pulse_scheduler: one instance with a 3-cycle gap
// and one with no gap, driven through their interfaces.
module tb_led_pulse_scheduler;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    led_pulse_scheduler_if #(.NUM_REQ(4)) ifa ();
    led_pulse_scheduler_if #(.NUM_REQ(4)) ifb ();

    led_pulse_scheduler #(.NUM_REQ(4), .CLOCK_HZ(25_000_000), .GAP_CYCLES(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    led_pulse_scheduler #(.NUM_REQ(4), .CLOCK_HZ(25_000_000), .GAP_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic strobe_a(input logic [3:0] m);
        ifa.req = m;
        step();
        ifa.req = 4'd0;
    endtask

    task automatic wait_trig_a(input string tag, input logic [2:0] exp_owner);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ifa.trigger && n < 60);
        chk_val({tag, "_seen"}, 32'(ifa.trigger), 32'd1);
        chk_val({tag, "_owner"}, 32'(ifa.owner), 32'(exp_owner));
    endtask

    task automatic set_all_len_a(input logic [31:0] v);
        for (int i = 0; i < 4; i++) ifa.pulse_len[32*i +: 32] = v;
    endtask

    initial begin
        int cnt;
        int trig;
        int t_prev;
        int nt;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        ifa.req = 4'd0;
        ifa.enable = 1'b1;
        ifa.pulse_len = '0;
        ifb.req = 4'd0;
        ifb.enable = 1'b1;
        ifb.pulse_len = '0;
        #2;
        do_reset();

        // Reset state
        chk_val("rst_trigger", 32'(ifa.trigger), 32'd0);
        chk_val("rst_pulse_cycles", ifa.pulse_cycles, 32'd0);
        chk_val("rst_owner", 32'(ifa.owner), 32'd0);
        chk_val("rst_busy", 32'(ifa.busy), 32'd0);
        chk_val("rst_pending", 32'(ifa.pending), 32'd0);
        chk_val("rst_drop", 32'(ifa.drop_count), 32'd0);

        // Single request: latency, pulse length, busy duration
        ifa.pulse_len[31:0] = 32'd5;
        strobe_a(4'b0001);
        chk_val("t1_pending_latched", 32'(ifa.pending), 32'h1);
        chk_val("t1_no_trig_yet", 32'(ifa.trigger), 32'd0);
        step();
        chk_val("t1_trigger", 32'(ifa.trigger), 32'd1);
        chk_val("t1_pulse_cycles", ifa.pulse_cycles, 32'd5);
        chk_val("t1_owner", 32'(ifa.owner), 32'd0);
        chk_val("t1_pending_clr", 32'(ifa.pending), 32'd0);
        cnt = 0;
        trig = 0;
        while (ifa.busy && cnt < 50) begin
            cnt++;
            trig += int'(ifa.trigger);
            step();
        end
        chk_val("t1_busy_cycles", 32'(cnt), 32'd8);
        chk_val("t1_trigger_cycles", 32'(trig), 32'd1);

        // All four at once: order 0,1,2,3, triggers 2+3+1 = 6 cycles apart
        do_reset();
        set_all_len_a(32'd2);
        strobe_a(4'b1111);
        chk_val("t2_pending", 32'(ifa.pending), 32'hF);
        nt = 0;
        t_prev = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (ifa.trigger) begin
                chk_val($sformatf("t2_owner%0d", nt), 32'(ifa.owner), 32'(nt));
                if (nt > 0) chk_val($sformatf("t2_spacing%0d", nt), 32'(c - t_prev), 32'd6);
                t_prev = c;
                nt++;
            end
        end
        chk_val("t2_grant_count", 32'(nt), 32'd4);
        chk_val("t2_drop", 32'(ifa.drop_count), 32'd0);

        // Fairness: search starts after last winner and wraps
        do_reset();
        set_all_len_a(32'd2);
        strobe_a(4'b0100);
        wait_trig_a("t3_g2", 3'd2);
        strobe_a(4'b0101);
        wait_trig_a("t3_g0", 3'd0);
        strobe_a(4'b0001);
        chk_val("t3_pending", 32'(ifa.pending), 32'h5);
        wait_trig_a("t3_g2b", 3'd2);
        wait_trig_a("t3_g0b", 3'd0);
        chk_val("t3_drop", 32'(ifa.drop_count), 32'd0);

        // Coalescing and request during own grant cycle
        do_reset();
        ifa.pulse_len[31:0] = 32'd4;
        ifa.pulse_len[63:32] = 32'd2;
        ifa.req = 4'b0001;
        step();
        ifa.req = 4'b0001;
        step();
        ifa.req = 4'b0000;
        chk_val("t4_grant_trig", 32'(ifa.trigger), 32'd1);
        chk_val("t4_pending0_kept", 32'(ifa.pending), 32'h1);
        chk_val("t4_drop_after_grant", 32'(ifa.drop_count), 32'd0);
        strobe_a(4'b0010);
        strobe_a(4'b0010);
        strobe_a(4'b0010);
        chk_val("t4_drop", 32'(ifa.drop_count), 32'd2);
        chk_val("t4_pending", 32'(ifa.pending), 32'h3);
        wait_trig_a("t4_g1", 3'd1);
        chk_val("t4_len1", ifa.pulse_cycles, 32'd2);
        wait_trig_a("t4_g0", 3'd0);
        chk_val("t4_pending_empty", 32'(ifa.pending), 32'd0);
        chk_val("t4_drop_final", 32'(ifa.drop_count), 32'd2);

        // Zero length and zero gap on the second instance
        ifb.req = 4'b0011;
        step();
        ifb.req = 4'b0000;
        step();
        chk_val("t5_trig0", 32'(ifb.trigger), 32'd1);
        chk_val("t5_len_clamp", ifb.pulse_cycles, 32'd1);
        chk_val("t5_owner0", 32'(ifb.owner), 32'd0);
        step();
        chk_val("t5_trig_gap", 32'(ifb.trigger), 32'd0);
        chk_val("t5_idle_after_1", 32'(ifb.busy), 32'd0);
        step();
        chk_val("t5_trig1", 32'(ifb.trigger), 32'd1);
        chk_val("t5_owner1", 32'(ifb.owner), 32'd1);

        // Enable hold, then reset mid-pulse
        do_reset();
        ifa.pulse_len[31:0] = 32'd4;
        ifa.pulse_len[63:32] = 32'd3;
        strobe_a(4'b0001);
        step();
        chk_val("t6_trig0", 32'(ifa.trigger), 32'd1);
        step();
        ifa.enable = 1'b0;
        strobe_a(4'b0010);
        chk_val("t6_pending_hold", 32'(ifa.pending), 32'h2);
        trig = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            trig += int'(ifa.trigger);
        end
        chk_val("t6_no_trig_disabled", 32'(trig), 32'd0);
        chk_val("t6_idle_disabled", 32'(ifa.busy), 32'd0);
        chk_val("t6_pending_still", 32'(ifa.pending), 32'h2);
        ifa.enable = 1'b1;
        step();
        chk_val("t6_trig_enable", 32'(ifa.trigger), 32'd1);
        chk_val("t6_owner_enable", 32'(ifa.owner), 32'd1);
        chk_val("t6_len_enable", ifa.pulse_cycles, 32'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_val("t6_rst_busy", 32'(ifa.busy), 32'd0);
        chk_val("t6_rst_owner", 32'(ifa.owner), 32'd0);
        chk_val("t6_rst_pulse_cycles", ifa.pulse_cycles, 32'd0);
        chk_val("t6_rst_trigger", 32'(ifa.trigger), 32'd0);
        chk_val("t6_rst_drop", 32'(ifa.drop_count), 32'd0);
        strobe_a(4'b0011);
        step();
        chk_val("t6_post_rst_trig", 32'(ifa.trigger), 32'd1);
        chk_val("t6_post_rst_owner", 32'(ifa.owner), 32'd0);

        // Maximum length must not wrap
        do_reset();
        ifa.pulse_len[31:0] = 32'hFFFF_FFFF;
        strobe_a(4'b0001);
        step();
        chk_val("t7_max_len", ifa.pulse_cycles, 32'hFFFF_FFFF);
        for (int c = 0; c < 10; c++) step();
        chk_val("t7_still_busy", 32'(ifa.busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
